// File: rtl/div_repeated_sub_if.sv
// rtl/div_repeated_sub_if.sv - start/done handshake and operand/result bundle for the divider
interface div_repeated_sub_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  // Requester side: issues start and operands, observes results
  modport master (
    output start,
    output dividend,
    output divisor,
    input  busy,
    input  done,
    input  quotient,
    input  remainder,
    input  div_by_zero
  );

  // Divider side
  modport slave (
    input  start,
    input  dividend,
    input  divisor,
    output busy,
    output done,
    output quotient,
    output remainder,
    output div_by_zero
  );
endinterface

// File: rtl/div_repeated_sub.sv
// rtl/div_repeated_sub.sv - sequential unsigned divider, one subtraction per clock
module div_repeated_sub #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  div_repeated_sub_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] r_q;      // running remainder
  logic [WIDTH-1:0] d_q;      // captured divisor
  logic [WIDTH-1:0] q_q;      // running quotient; never exceeds the dividend so cannot wrap
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;

  logic             ge_d;
  logic [WIDTH-1:0] r_sub_d;
  logic [WIDTH-1:0] q_inc_d;

  // Datapath: one compare, one subtract and one increment per clock
  always_comb begin
    ge_d    = (r_q >= d_q);
    r_sub_d = r_q - d_q;
    q_inc_d = q_q + {{(WIDTH-1){1'b0}}, 1'b1};
  end

  // Controller FSM with registered outputs; results load on entry to DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      d_q     <= '0;
      q_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            r_q    <= bus.dividend;
            d_q    <= bus.divisor;
            q_q    <= '0;
            busy_q <= 1'b1;
            if (bus.divisor == '0) begin
              // No iterations: report saturated quotient and the dividend as remainder
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              dbz_q   <= 1'b1;
              quot_q  <= '1;
              rem_q   <= bus.dividend;
            end else begin
              state_q <= ST_SUB;
              dbz_q   <= 1'b0;
            end
          end
        end

        ST_SUB: begin
          if (ge_d) begin
            r_q <= r_sub_d;
            q_q <= q_inc_d;
          end else begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            quot_q  <= q_q;
            rem_q   <= r_q;
          end
        end

        ST_DONE: begin
          // Single-cycle done pulse, then always return to IDLE
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_repeated_sub.sv
// tb/tb_div_repeated_sub.sv - scoreboard bench for div_repeated_sub against an arithmetic model
module tb_div_repeated_sub;
  localparam int W = 16;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;
  logic prev_done;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           done_cyc;
  } exp_t;

  exp_t exp_q[$];

  div_repeated_sub_if #(.WIDTH(W)) bus ();

  div_repeated_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer division; latency = quotient+1 edges, or 0 for a zero divisor
  function automatic exp_t model(input int a, input int b, input int acc_cyc);
    exp_t e;
    if (b == 0) begin
      e.q        = 16'hFFFF;
      e.r        = a[W-1:0];
      e.dbz      = 1'b1;
      e.done_cyc = acc_cyc;
    end else begin
      e.q        = W'(a / b);
      e.r        = W'(a % b);
      e.dbz      = 1'b0;
      e.done_cyc = acc_cyc + (a / b) + 1;
    end
    return e;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((bus.busy || bus.done) && n < 70000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 70000) chk("idle_timeout", 32'(n), 32'd0);
  endtask

  // Issue one operation on a guaranteed accept edge; operands are scrambled afterwards
  task automatic run_op(input int a, input int b);
    int acc;
    wait_idle();
    bus.dividend = W'(a);
    bus.divisor  = W'(b);
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    bus.start    = 1'b0;
    bus.dividend = W'($urandom);
    bus.divisor  = W'($urandom);
    exp_q.push_back(model(a, b, acc));
  endtask

  // Monitor: compares every done pulse against the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) begin
        if (prev_done) chk("done_width", 32'd2, 32'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("quotient", 32'(bus.quotient), 32'(e.q));
          chk("remainder", 32'(bus.remainder), 32'(e.r));
          chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
          chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
          chk("busy_with_done", 32'(bus.busy), 32'd1);
        end
      end
      prev_done = bus.done;
    end else begin
      prev_done = 1'b0;
    end
  end

  initial begin
    int a1, a2, n;
    total     = 0;
    bad       = 0;
    cyc       = 0;
    prev_done = 1'b0;
    rst_n     = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_quotient", 32'(bus.quotient), 32'd0);
    chk("rst_remainder", 32'(bus.remainder), 32'd0);
    chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases including boundaries
    run_op(17, 5);
    run_op(4, 5);
    run_op(0, 7);
    run_op(100, 0);
    run_op(300, 300);
    run_op(65535, 1);

    // start pulsed while busy must be ignored
    run_op(200, 3);
    repeat (5) @(negedge clk);
    bus.dividend = 16'd77;
    bus.divisor  = 16'd2;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;

    // start held high: back-to-back ops with one idle cycle between them
    wait_idle();
    bus.dividend = 16'd50;
    bus.divisor  = 16'd7;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    a1 = cyc;
    exp_q.push_back(model(50, 7, a1));
    a2 = a1 + (50 / 7) + 1 + 2;
    exp_q.push_back(model(50, 7, a2));
    n = 0;
    while (cyc < a2 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b_second_accept_busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;

    // Reset mid-SUB: outputs clear asynchronously, no done pulse
    run_op(1000, 3);
    repeat (20) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_quotient", 32'(bus.quotient), 32'd0);
    chk("midrst_remainder", 32'(bus.remainder), 32'd0);
    chk("midrst_dbz", 32'(bus.div_by_zero), 32'd0);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(9, 2);

    // Randomized operations with occasional zero divisor and random gaps
    for (int i = 0; i < 30; i++) begin
      int a, b;
      a = $urandom_range(0, 400);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 25);
      run_op(a, b);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
